ram_session_controller: RTL and testbench

//  Sequences one processing session around the CPU and owns the shared data RAM port.

---
 rtl/ram_session_controller.sv | 196 +++++++++++++++++++
 tb/tb_ram_session_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_session_controller.sv
// rtl/ram_session_controller.sv - LOAD/RUN/DUMP session sequencer owning the shared data RAM port
// Optional RUN watchdog enabled by defining TIMEOUT_EN.
module ram_session_controller #(
    parameter int          ADDR_W         = 16,
    parameter int          DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              MAIN_CLOCK,
    input  logic              RESET_N,
    input  logic              GO,
    input  logic [ADDR_W-1:0] LOAD_LEN,
    input  logic [ADDR_W-1:0] DUMP_BASE,
    input  logic [ADDR_W-1:0] DUMP_LEN,
    input  logic              HOST_IN_VALID,
    input  logic [DATA_W-1:0] HOST_IN_DATA,
    output logic              HOST_IN_READY,
    output logic              HOST_OUT_VALID,
    output logic [DATA_W-1:0] HOST_OUT_DATA,
    input  logic              HOST_OUT_READY,
    output logic              START_PROCESSING_FLAG,
    input  logic              PROCESS_FINISHED,
    input  logic [ADDR_W-1:0] CPU_ADDRESS,
    input  logic [DATA_W-1:0] CPU_DATA,
    input  logic              CPU_WRITE_EN,
    output logic [DATA_W-1:0] DATA_FROM_RAM,
    output logic [ADDR_W-1:0] RAM_ADDRESS,
    output logic [DATA_W-1:0] RAM_WDATA,
    output logic              RAM_WE,
    input  logic [DATA_W-1:0] RAM_RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic [2:0]        STATE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DUMP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {D_ADDR, D_CAP, D_HOLD} dump_phase_t;

`ifdef TIMEOUT_EN
    localparam bit WATCHDOG_ON = 1'b1;
`else
    localparam bit WATCHDOG_ON = 1'b0;
`endif

    state_t            state;
    dump_phase_t       phase;
    logic [ADDR_W-1:0] load_len_q;
    logic [ADDR_W-1:0] dump_base_q;
    logic [ADDR_W-1:0] dump_len_q;
    logic [ADDR_W-1:0] cnt;
    logic              load_last;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              ram_we_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic [31:0]       wd_cnt;
    logic              timeout_hit;

    assign timeout_hit = WATCHDOG_ON && (state == S_RUN) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    // The CPU owns the RAM port only while RUN; elsewhere the registered load/dump port drives it.
    assign RAM_ADDRESS = (state == S_RUN) ? CPU_ADDRESS  : ram_addr_q;
    assign RAM_WDATA   = (state == S_RUN) ? CPU_DATA     : ram_wdata_q;
    assign RAM_WE      = (state == S_RUN) ? CPU_WRITE_EN : ram_we_q;

    assign DATA_FROM_RAM         = RAM_RDATA;
    assign HOST_IN_READY         = (state == S_LOAD) && !load_last;
    assign HOST_OUT_VALID        = out_valid_q;
    assign HOST_OUT_DATA         = out_data_q;
    assign START_PROCESSING_FLAG = start_q;
    assign BUSY                  = busy_q;
    assign DONE                  = done_q;
    assign ERROR                 = error_q;
    assign STATE                 = state;

    always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            phase       <= D_ADDR;
            load_len_q  <= '0;
            dump_base_q <= '0;
            dump_len_q  <= '0;
            cnt         <= '0;
            load_last   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            ram_we_q <= 1'b0;
            wd_cnt   <= (state == S_RUN) ? wd_cnt + 32'd1 : 32'd0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (GO) begin
                        load_len_q  <= LOAD_LEN;
                        dump_base_q <= DUMP_BASE;
                        dump_len_q  <= DUMP_LEN;
                        cnt         <= '0;
                        load_last   <= 1'b0;
                        error_q     <= 1'b0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        if (LOAD_LEN == '0) begin
                            state   <= S_RUN;
                            start_q <= 1'b1;
                        end else begin
                            state   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    // One extra cycle after the last beat lets its write land before START rises.
                    if (load_last) begin
                        state     <= S_RUN;
                        start_q   <= 1'b1;
                        load_last <= 1'b0;
                    end else if (HOST_IN_VALID) begin
                        ram_we_q    <= 1'b1;
                        ram_addr_q  <= cnt;
                        ram_wdata_q <= HOST_IN_DATA;
                        cnt         <= cnt + 1'b1;
                        if (cnt == load_len_q - 1'b1) begin
                            load_last <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (PROCESS_FINISHED) begin
                        start_q <= 1'b0;
                        cnt     <= '0;
                        if (dump_len_q == '0) begin
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state      <= S_DUMP;
                            ram_addr_q <= dump_base_q;
                            phase      <= D_ADDR;
                        end
                    end else if (timeout_hit) begin
                        start_q <= 1'b0;
                        error_q <= 1'b1;
                        state   <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DUMP: begin
                    case (phase)
                        D_ADDR: phase <= D_CAP;
                        D_CAP: begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= RAM_RDATA;
                            phase       <= D_HOLD;
                        end
                        D_HOLD: begin
                            if (HOST_OUT_READY) begin
                                out_valid_q <= 1'b0;
                                cnt         <= cnt + 1'b1;
                                if (cnt == dump_len_q - 1'b1) begin
                                    state  <= S_DONE;
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end else begin
                                    ram_addr_q <= dump_base_q + cnt + 1'b1;
                                    phase      <= D_ADDR;
                                end
                            end
                        end
                        default: phase <= D_ADDR;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_session_controller.sv
// tb/tb_ram_session_controller.sv - directed bench for ram_session_controller with a behavioural data RAM
module tb_ram_session_controller;

    logic        main_clock;
    logic        reset_n;
    logic        go;
    logic [15:0] load_len, dump_base, dump_len;
    logic        host_in_valid;
    logic [7:0]  host_in_data;
    logic        host_in_ready;
    logic        host_out_valid;
    logic [7:0]  host_out_data;
    logic        host_out_ready;
    logic        start_flag;
    logic        process_finished;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data;
    logic        cpu_write_en;
    logic [7:0]  data_from_ram;
    logic [15:0] ram_address;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic        busy, done, error;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    logic [7:0]  dump_q[$];
    int          out_valid_cnt = 0;

    ram_session_controller #(.ADDR_W(16), .DATA_W(8), .TIMEOUT_CYCLES(50)) dut (
        .MAIN_CLOCK(main_clock), .RESET_N(reset_n), .GO(go),
        .LOAD_LEN(load_len), .DUMP_BASE(dump_base), .DUMP_LEN(dump_len),
        .HOST_IN_VALID(host_in_valid), .HOST_IN_DATA(host_in_data), .HOST_IN_READY(host_in_ready),
        .HOST_OUT_VALID(host_out_valid), .HOST_OUT_DATA(host_out_data), .HOST_OUT_READY(host_out_ready),
        .START_PROCESSING_FLAG(start_flag), .PROCESS_FINISHED(process_finished),
        .CPU_ADDRESS(cpu_address), .CPU_DATA(cpu_data), .CPU_WRITE_EN(cpu_write_en),
        .DATA_FROM_RAM(data_from_ram),
        .RAM_ADDRESS(ram_address), .RAM_WDATA(ram_wdata), .RAM_WE(ram_we), .RAM_RDATA(ram_rdata),
        .BUSY(busy), .DONE(done), .ERROR(error), .STATE(state_o)
    );

    initial main_clock = 1'b0;
    always #5 main_clock = ~main_clock;

    always @(posedge main_clock) begin
        if (ram_we) begin
            mem[ram_address] <= ram_wdata;
            wr_addr_log.push_back(ram_address);
            wr_data_log.push_back(ram_wdata);
        end
        ram_rdata <= mem[ram_address];
        if (host_out_valid && host_out_ready) dump_q.push_back(host_out_data);
        if (host_out_valid) out_valid_cnt++;
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        logic        exp_we_run;
    } cpu_vec_t;

    cpu_vec_t cpu_vecs [4];

    task automatic tick();
        @(posedge main_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state_o !== s && n < budget) begin
            tick();
            n++;
        end
        check(name, {29'd0, state_o}, {29'd0, s});
    endtask

    task automatic start_session(input logic [15:0] ll, input logic [15:0] db, input logic [15:0] dl);
        load_len = ll; dump_base = db; dump_len = dl; go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_finished();
        process_finished = 1'b1;
        tick();
        process_finished = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1_bytes [4];
        int         n;
        int         start_cycles;
        int         wr_before;
        int         vcnt_before;
        logic       stable;
        t1_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        cpu_vecs[0] = '{16'h0010, 8'h5A, 1'b1, 1'b1};
        cpu_vecs[1] = '{16'h0011, 8'h6B, 1'b1, 1'b1};
        cpu_vecs[2] = '{16'h0012, 8'h7C, 1'b1, 1'b1};
        cpu_vecs[3] = '{16'h0100, 8'h99, 1'b0, 1'b0};

        reset_n = 1'b0; go = 1'b0; load_len = '0; dump_base = '0; dump_len = '0;
        host_in_valid = 1'b0; host_in_data = '0; host_out_ready = 1'b0;
        process_finished = 1'b0; cpu_address = '0; cpu_data = '0; cpu_write_en = 1'b0;
        tick(); tick();
        check("rst_state", {29'd0, state_o}, 32'd0);
        check("rst_busy_done_err", {29'd0, busy, done, error}, 32'd0);
        check("rst_start", {31'd0, start_flag}, 32'd0);
        check("rst_ready_valid", {30'd0, host_in_ready, host_out_valid}, 32'd0);
        check("rst_ram_port", {15'd0, ram_we, ram_address}, 32'd0);
        reset_n = 1'b1;
        tick();

        // host input in IDLE must be refused and must not touch RAM
        host_in_valid = 1'b1; host_in_data = 8'hEE;
        tick(); tick();
        check("idle_in_ready", {31'd0, host_in_ready}, 32'd0);
        check("idle_in_no_write", wr_addr_log.size(), 32'd0);
        host_in_valid = 1'b0;

        // T1: load four bytes with a one-cycle VALID gap between beats
        start_session(16'd4, 16'h0010, 16'd3);
        check("t1_state_load", {29'd0, state_o}, 32'd1);
        check("t1_ready", {31'd0, host_in_ready}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            host_in_valid = 1'b1; host_in_data = t1_bytes[i];
            tick();
            host_in_valid = 1'b0;
            if (i < 3) tick();
        end
        check("t1_last_write", {7'd0, ram_we, ram_address, ram_wdata}, {7'd0, 1'b1, 16'd3, 8'hD4});
        check("t1_start_not_yet", {31'd0, start_flag}, 32'd0);
        check("t1_ready_after_last", {31'd0, host_in_ready}, 32'd0);
        tick();
        check("t1_start_rise", {31'd0, start_flag}, 32'd1);
        check("t1_state_run", {29'd0, state_o}, 32'd2);
        check("t1_write_count", wr_addr_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
            check($sformatf("t1_write%0d", i), {8'd0, wr_addr_log[i], wr_data_log[i]},
                  {8'd0, 16'(i), t1_bytes[i]});
        end

        // T2: CPU port is muxed onto the RAM while RUN
        for (int i = 0; i < 4; i++) begin
            cpu_address = cpu_vecs[i].addr; cpu_data = cpu_vecs[i].data; cpu_write_en = cpu_vecs[i].we;
            #1;
            check($sformatf("t2_cpu_mux%0d", i), {7'd0, ram_we, ram_address, ram_wdata},
                  {7'd0, cpu_vecs[i].exp_we_run, cpu_vecs[i].addr, cpu_vecs[i].data});
            tick();
        end
        cpu_write_en = 1'b0;
        check("t2_cpu_writes", wr_addr_log.size(), 32'd7);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("t2_go_ignored_run", {29'd0, state_o}, 32'd2);
        for (int i = 0; i < 90; i++) tick();
        check("t2_still_running", {31'd0, start_flag}, 32'd1);
        host_out_ready = 1'b0;
        pulse_finished();
        check("t2_state_dump", {29'd0, state_o}, 32'd3);
        check("t2_start_fall", {31'd0, start_flag}, 32'd0);
        n = 0;
        while (!host_out_valid && n < 10) begin tick(); n++; end
        check("t2_first_valid", {31'd0, host_out_valid}, 32'd1);
        check("t2_first_data", {24'd0, host_out_data}, 32'h5A);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!host_out_valid || host_out_data !== 8'h5A || ram_we) stable = 1'b0;
        end
        check("t2_stall_stable", {31'd0, stable}, 32'd1);
        check("t2_passthrough", {24'd0, data_from_ram}, {24'd0, ram_rdata});
        host_out_ready = 1'b1;
        wait_state(3'd4, 60, "t2_reach_done");
        check("t2_dump_count", dump_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < dump_q.size(); i++) begin
            check($sformatf("t2_dump%0d", i), {24'd0, dump_q[i]}, {24'd0, cpu_vecs[i].data});
        end
        check("t2_done_flags", {29'd0, busy, done, host_out_valid}, 32'b010);
        check("t2_no_dump_write", wr_addr_log.size(), 32'd7);

        // CPU writes and FINISHED outside RUN have no effect
        for (int i = 0; i < 4; i++) begin
            cpu_address = cpu_vecs[i].addr; cpu_data = cpu_vecs[i].data; cpu_write_en = cpu_vecs[i].we;
            #1;
            check($sformatf("t2_cpu_blocked%0d", i), {31'd0, ram_we}, 32'd0);
            tick();
        end
        cpu_write_en = 1'b0;
        pulse_finished();
        check("t2_finished_ignored", {29'd0, state_o}, 32'd4);

        // T3: zero-length load and dump
        vcnt_before = out_valid_cnt;
        start_session(16'd0, 16'h0000, 16'd0);
        check("t3_direct_run", {28'd0, state_o, start_flag}, {28'd0, 3'd2, 1'b1});
        check("t3_done_cleared", {31'd0, done}, 32'd0);
        tick(); tick();
        pulse_finished();
        check("t3_done", {28'd0, state_o, done}, {28'd0, 3'd4, 1'b1});
        check("t3_no_out_valid", out_valid_cnt - vcnt_before, 32'd0);

        // T4: dump window wrapping from 0xFFFF to 0x0000
        dump_q.delete();
        start_session(16'd0, 16'hFFFF, 16'd2);
        cpu_address = 16'hFFFF; cpu_data = 8'h3C; cpu_write_en = 1'b1;
        tick();
        cpu_write_en = 1'b0;
        pulse_finished();
        host_out_ready = 1'b1;
        wait_state(3'd4, 40, "t4_reach_done");
        check("t4_dump_count", dump_q.size(), 32'd2);
        if (dump_q.size() == 2) begin
            check("t4_dump_ffff", {24'd0, dump_q[0]}, 32'h3C);
            check("t4_dump_0000", {24'd0, dump_q[1]}, 32'hA1);
        end

`ifdef TIMEOUT_EN
        // T6: watchdog fires after 50 RUN cycles
        vcnt_before = out_valid_cnt;
        start_session(16'd0, 16'h0000, 16'd2);
        start_cycles = 0;
        while (start_flag && start_cycles < 200) begin start_cycles++; tick(); end
        check("t6_run_cycles", start_cycles, 32'd50);
        check("t6_error_done", {27'd0, state_o, error, done}, {27'd0, 3'd4, 1'b1, 1'b1});
        check("t6_no_dump", out_valid_cnt - vcnt_before, 32'd0);
        start_session(16'd0, 16'h0000, 16'd0);
        check("t6_error_cleared", {31'd0, error}, 32'd0);
        pulse_finished();
`else
        start_session(16'd0, 16'h0000, 16'd0);
        start_cycles = 0;
        while (start_flag && start_cycles < 80) begin start_cycles++; tick(); end
        check("t6_no_watchdog", start_cycles, 32'd80);
        check("t6_error_low", {31'd0, error}, 32'd0);
        pulse_finished();
`endif

        // T5: asynchronous reset in the middle of LOAD
        start_session(16'd4, 16'h0000, 16'd0);
        for (int i = 0; i < 2; i++) begin
            host_in_valid = 1'b1; host_in_data = t1_bytes[i];
            tick();
        end
        host_in_valid = 1'b0;
        check("t5_mid_write", {15'd0, ram_we, ram_address}, {15'd0, 1'b1, 16'd1});
        reset_n = 1'b0;
        #1;
        check("t5_reset_state", {29'd0, state_o}, 32'd0);
        check("t5_reset_outputs", {29'd0, ram_we, start_flag, host_in_ready}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        start_session(16'd2, 16'h0000, 16'd0);
        host_in_valid = 1'b1; host_in_data = 8'h11;
        tick();
        host_in_valid = 1'b0;
        check("t5_restart_addr0", {7'd0, ram_we, ram_address, ram_wdata}, {7'd0, 1'b1, 16'd0, 8'h11});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
